weight_loader: RTL

- Upstream feeder for the per-column weight buffer bank.
- Accepts a column-major weight stream over a valid/ready handshake and steers each beat into the correct column buffer with a one-hot write enable.
- Once a full tile of SYS_COLS x ROWS weights is written, issues the single `read` pulse train that starts the skewed readout into the systolic array.
- Signals completion with a `done` pulse.

---
 rtl/weight_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/weight_loader.sv
// Weight loader: steers a column-major weight stream into the per-column buffers,
// then issues the read pulse train that starts the skewed readout into the array.
module weight_loader #(
   parameter int SYS_COLS   = 4,
   parameter int W_BITWIDTH = 8,
   parameter int ROWS       = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [W_BITWIDTH-1:0]          s_data,
   input  logic                           s_last,
   output logic [SYS_COLS-1:0]            wr_en,
   output logic [SYS_COLS*W_BITWIDTH-1:0] wr_data,
   output logic                           read,
   output logic                           busy,
   output logic                           done,
   output logic                           err
);

   localparam int COL_W   = (SYS_COLS > 1) ? $clog2(SYS_COLS) : 1;
   localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CNT_MAX = (ROWS > SYS_COLS) ? ROWS : SYS_COLS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(SYS_COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(ROWS - 1);
   localparam logic [CNT_W-1:0] SKEW_LAST = CNT_W'(SYS_COLS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_READ,
      S_SKEW,
      S_DONE
   } state_t;

   state_t              state;
   logic [COL_W-1:0]    col;
   logic [ROW_W-1:0]    row;
   logic [CNT_W-1:0]    cnt;
   logic [SYS_COLS-1:0] col_onehot;
   logic                beat;
   logic                final_beat;

   assign s_ready    = (state == S_LOAD);
   assign busy       = (state != S_IDLE);
   assign beat       = s_valid & s_ready;
   assign final_beat = (col == COL_LAST) && (row == ROW_LAST);

   always_comb begin
      col_onehot = '0;
      for (int i = 0; i < SYS_COLS; i++)
         col_onehot[i] = (col == COL_W'(i));
   end

   // NOTE: all state and registered outputs use non-blocking assignments so every
   // branch below sees the pre-edge values of col/row/cnt regardless of order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         col     <= '0;
         row     <= '0;
         cnt     <= '0;
         wr_en   <= '0;
         wr_data <= '0;
         read    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         wr_en <= '0;
         read  <= 1'b0;
         done  <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_LOAD;
                  col   <= '0;
                  row   <= '0;
                  err   <= 1'b0;
               end
            end

            S_LOAD: begin
               if (beat) begin
                  wr_en   <= col_onehot;
                  wr_data <= {SYS_COLS{s_data}};
                  if (final_beat) begin
                     state <= S_SETTLE;
                     if (!s_last) err <= 1'b1;
                  end else begin
                     // early s_last is a framing error, but the beat still lands
                     if (s_last) err <= 1'b1;
                     if (row == ROW_LAST) begin
                        row <= '0;
                        col <= col + COL_W'(1);
                     end else begin
                        row <= row + ROW_W'(1);
                     end
                  end
               end
            end

            S_SETTLE: begin
               state <= S_READ;
               cnt   <= '0;
               read  <= 1'b1;
            end

            S_READ: begin
               if (cnt == READ_LAST) begin
                  state <= S_SKEW;
                  cnt   <= '0;
               end else begin
                  cnt  <= cnt + CNT_W'(1);
                  read <= 1'b1;
               end
            end

            // column skew plus the buffer's own read latency
            S_SKEW: begin
               if (cnt == SKEW_LAST) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_DONE: state <= S_IDLE;

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
